// File: rtl/data_ram_ctrl.sv
// Data-side RAM responder for the MEM stage: multi-cycle load/store with byte-lane writes.
// Optional macro DRAM_BUS_ERR_EN flags out-of-range addresses via bus_err_o instead of aliasing.
module data_ram_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        stallreq_o,
  output logic        bus_err_o
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = 4;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  we_q, we_d;
  logic [LANES-1:0]      sel_q, sel_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  oob_q, oob_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic                  bus_err_q, bus_err_d;
  logic                  commit_c;
  logic                  ram_we_c;
  logic                  oob_c;
  logic                  unused_addr_c;

  logic [DATA_W-1:0] mem [DEPTH];

`ifdef DRAM_BUS_ERR_EN
  assign oob_c = (addr_i[31:ADDR_WIDTH+2] != '0);
`else
  assign oob_c = 1'b0;
`endif

  // Byte offset is handled by MEM; upper bits only matter for the range check.
  assign unused_addr_c = ^{addr_i[31:ADDR_WIDTH+2], addr_i[1:0]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    we_d       = we_q;
    sel_d      = sel_q;
    wdata_d    = wdata_q;
    oob_d      = oob_q;
    data_d     = data_q;
    bus_err_d  = bus_err_q;
    commit_c   = 1'b0;
    stallreq_o = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        stallreq_o = ce_i;
        if (ce_i) begin
          state_d = S_ACCESS;
          cnt_d   = '0;
          idx_d   = addr_i[ADDR_WIDTH+1:2];
          we_d    = we_i;
          sel_d   = sel_i;
          wdata_d = data_i;
          oob_d   = oob_c;
        end
      end
      S_ACCESS: begin
        stallreq_o = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d   = S_DONE;
          commit_c  = 1'b1;
          bus_err_d = oob_q;
          data_d    = (we_q || oob_q) ? '0 : mem[idx_q];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        data_d    = '0;
        bus_err_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A reset on the commit edge suppresses the write.
  assign ram_we_c = commit_c && we_q && !oob_q && !rst;

  always_ff @(posedge clk) begin
    if (ram_we_c) begin
      for (int i = 0; i < LANES; i++) begin
        if (sel_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      wdata_q   <= '0;
      oob_q     <= 1'b0;
      data_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      wdata_q   <= wdata_d;
      oob_q     <= oob_d;
      data_q    <= data_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign data_o    = data_q;
  assign bus_err_o = bus_err_q;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Scoreboard bench for data_ram_ctrl (WAIT_CYCLES=3, ADDR_WIDTH=12); honours DRAM_BUS_ERR_EN.
module tb_data_ram_ctrl;

  localparam int unsigned AW   = 12;
  localparam int unsigned WAIT = 3;

  logic        clk;
  logic        rst;
  logic        ce_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [3:0]  sel_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        stallreq_o;
  logic        bus_err_o;

  data_ram_ctrl #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WAIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce_i       (ce_i),
    .we_i       (we_i),
    .addr_i     (addr_i),
    .sel_i      (sel_i),
    .data_i     (data_i),
    .data_o     (data_o),
    .stallreq_o (stallreq_o),
    .bus_err_o  (bus_err_o)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          gap;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 0;
  bit   stall_prev = 0;
  bit   rst_prev = 0;
  int   run = 0;
  int   cyc = 0;
  int   last_done = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: a DONE cycle is the first non-stall cycle after a stall run not cut by reset.
  always @(negedge clk) begin
    if (mon_en) begin
      if (stallreq_o) begin
        run++;
      end else if (stall_prev && !rst_prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_data", data_o, e.data);
          chk("done_bus_err", 32'(bus_err_o), 32'(e.err));
          chk("stall_len", 32'(run), 32'(WAIT + 1));
          if (e.gap != 0) chk("b2b_gap", 32'(cyc - last_done), 32'(e.gap));
        end
        last_done = cyc;
        run = 0;
      end else begin
        chk("idle_data", data_o, 32'h0);
        chk("idle_bus_err", 32'(bus_err_o), 32'h0);
        run = 0;
      end
      stall_prev = stallreq_o;
      rst_prev   = rst;
    end
    cyc++;
  end

  // Issue one request; returns in the DONE cycle (#1 after the edge).
  task automatic req(input logic we, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] d, input logic [31:0] ed, input logic ee,
                     input bit pulse, input bit b2b);
    if (!b2b) begin
      @(posedge clk); #1;
    end
    ce_i = 1'b1; we_i = we; addr_i = a; sel_i = s; data_i = d;
    sb.push_back('{ed, ee, b2b ? int'(WAIT + 2) : 0});
    if (b2b) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    if (pulse) begin
      ce_i = 1'b0; we_i = ~we; addr_i = $urandom; data_i = $urandom; sel_i = 4'($urandom);
    end
    for (int i = 0; i < 40 && stallreq_o; i++) begin
      @(posedge clk); #1;
    end
    if (stallreq_o) begin
      chk("done_timeout", 32'd1, 32'd0);
    end
    ce_i = 1'b0;
  endtask

  // Store aborted by reset after n ACCESS cycles (n == WAIT hits the commit edge).
  task automatic abort_store(input logic [31:0] a, input logic [31:0] d, input int n);
    @(posedge clk); #1;
    ce_i = 1'b1; we_i = 1'b1; addr_i = a; sel_i = 4'hF; data_i = d;
    @(posedge clk); #1;
    ce_i = 1'b0;
    repeat (n - 1) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    logic exp_err;
    logic [31:0] exp_w0;
    rst = 1'b1; ce_i = 1'b0; we_i = 1'b0; addr_i = '0; sel_i = '0; data_i = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // Word store/load, low address bits ignored
    req(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0, 0, 0);
    req(1'b0, 32'h10, 4'h0, 32'h0,        32'hDEADBEEF, 1'b0, 0, 0);
    req(1'b0, 32'h13, 4'h1, 32'h0,        32'hDEADBEEF, 1'b0, 0, 0);

    // Byte lanes
    req(1'b1, 32'h20, 4'hF,    32'h11223344, 32'h0,        1'b0, 0, 0);
    req(1'b1, 32'h20, 4'b0100, 32'h00AA0000, 32'h0,        1'b0, 1, 0);
    req(1'b0, 32'h20, 4'hF,    32'h0,        32'h11AA3344, 1'b0, 0, 0);
    req(1'b1, 32'h20, 4'b0000, 32'hFFFFFFFF, 32'h0,        1'b0, 0, 0);
    req(1'b0, 32'h20, 4'hF,    32'h0,        32'h11AA3344, 1'b0, 1, 0);

    // Back-to-back loads
    req(1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0, 0, 0);
    req(1'b0, 32'h20, 4'hF, 32'h0, 32'h11AA3344, 1'b0, 0, 1);

    // Reset mid-access and on the commit edge
    req(1'b1, 32'h40, 4'hF, 32'h0, 32'h0, 1'b0, 0, 0);
    abort_store(32'h40, 32'h55555555, 1);
    req(1'b0, 32'h40, 4'hF, 32'h0, 32'h0, 1'b0, 0, 0);
    abort_store(32'h40, 32'h55555555, int'(WAIT));
    req(1'b0, 32'h40, 4'hF, 32'h0, 32'h0, 1'b0, 0, 0);

    // Out-of-range address
`ifdef DRAM_BUS_ERR_EN
    exp_err = 1'b1;
    exp_w0  = 32'h12345678;
`else
    exp_err = 1'b0;
    exp_w0  = 32'hCAFEF00D;
`endif
    req(1'b1, 32'h0,        4'hF, 32'h12345678, 32'h0, 1'b0,    0, 0);
    req(1'b1, 32'h00010000, 4'hF, 32'hCAFEF00D, 32'h0, exp_err, 0, 0);
    req(1'b0, 32'h0,        4'hF, 32'h0,        exp_w0, 1'b0,   0, 0);

    repeat (4) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
